// File: rtl/fetch_unit.sv
// fetch_unit: decoupled instruction-fetch front end.
//
// Issues sequential word-aligned fetch requests over a valid/ready memory
// port, keeps in-order responses in a DEPTH-entry prefetch queue, and hands
// {pc, inst} pairs to decode over a valid/ready port. A redirect flushes the
// queue, retargets fetch and drops responses still in flight for the old path.
//
// Handshake rule (all ports): a transfer happens on a rising clk edge where
// valid and ready are both 1. A valid source never waits on ready to raise
// valid. imem_resp_valid has no ready; the credit rule guarantees space.
//
// Ports:
//   clk, rst                    clock; asynchronous active-low reset
//   imem_req_valid/ready/addr   fetch request (addr = word-aligned pc)
//   imem_resp_valid/inst        in-order fetch response
//   redirect_valid/pc           redirect from later stages (pulse or held)
//   out_valid/ready/pc/inst     {pc, inst} towards decode
//
// Optional feature: define FETCH_BYPASS_EN to forward a response straight to
// decode in the same cycle when the queue is empty (zero-cycle latency).
// Without it every response passes through the queue (one-cycle latency).
module fetch_unit #(
  parameter int               XLEN     = 64,
  parameter int               INST_W   = 32,
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = 64'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_inst,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst
);

  localparam int              CW      = $clog2(DEPTH + 1);
  localparam int              AW      = $clog2(DEPTH);
  localparam logic [CW:0]     DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [XLEN-1:0] STEP    = XLEN'(4);

  logic [XLEN-1:0]   req_pc;
  logic [XLEN-1:0]   resp_pc;
  logic [XLEN-1:0]   q_pc   [DEPTH];
  logic [INST_W-1:0] q_inst [DEPTH];
  logic [AW-1:0]     head;
  logic [AW-1:0]     tail;
  logic [CW-1:0]     count;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     drop;

  logic [XLEN-1:0]   target;
  logic              req_fire;
  logic              resp_keep;
  logic              bypass_hit;
  logic              push;
  logic              pop;

  assign target = {redirect_pc[XLEN-1:2], 2'b00};

  // Credit rule: queued entries plus outstanding requests never exceed
  // DEPTH, so every response that is kept always finds a free slot.
  assign imem_req_valid = rst && !redirect_valid &&
                          (({1'b0, count} + {1'b0, outstanding}) < DEPTH_W);
  assign imem_req_addr  = req_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response is kept only when it belongs to the current path.
  assign resp_keep = imem_resp_valid && !redirect_valid && (drop == '0);

`ifdef FETCH_BYPASS_EN
  assign bypass_hit = rst && resp_keep && (count == '0);
`else
  assign bypass_hit = 1'b0;
`endif

  assign out_valid = rst && !redirect_valid && ((count != '0) || bypass_hit);
  assign out_pc    = bypass_hit ? resp_pc        : q_pc[head];
  assign out_inst  = bypass_hit ? imem_resp_inst : q_inst[head];

  // A forwarded response that decode takes never enters the queue.
  assign pop  = (count != '0) && out_valid && out_ready;
  assign push = resp_keep && !(bypass_hit && out_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_pc      <= RESET_PC;
      resp_pc     <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_pc[i]   <= '0;
        q_inst[i] <= '0;
      end
    end else if (redirect_valid) begin
      // No request goes out this cycle; any response arriving now is wrong
      // path, everything else still in flight is counted into drop.
      req_pc      <= target;
      resp_pc     <= target;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      outstanding <= outstanding - CW'(imem_resp_valid);
      drop        <= outstanding - CW'(imem_resp_valid);
    end else begin
      if (req_fire) begin
        req_pc <= req_pc + STEP;
      end
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_resp_valid);
      if (imem_resp_valid && (drop != '0)) begin
        drop <= drop - CW'(1);
      end
      if (resp_keep) begin
        resp_pc <= resp_pc + STEP;
      end
      if (push) begin
        q_pc[tail]   <= resp_pc;
        q_inst[tail] <= imem_resp_inst;
        tail         <= tail + AW'(1);
      end
      if (pop) begin
        head <= head + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios plus a randomized phase,
// checked against a behavioural model of the memory and the fetch stream.
module tb_fetch_unit;

  localparam int          XLEN   = 64;
  localparam int          INST_W = 32;
  localparam int          DEPTH  = 4;
  localparam logic [63:0] RST_PC = 64'h8000_0000;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [XLEN-1:0]   imem_req_addr;
  logic              imem_resp_valid;
  logic [INST_W-1:0] imem_resp_inst;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_pc;
  logic [INST_W-1:0] out_inst;

  fetch_unit #(
    .XLEN(XLEN), .INST_W(INST_W), .DEPTH(DEPTH), .RESET_PC(RST_PC)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_inst(imem_resp_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (observed running, expected done)");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_req = 0;
  int n_out = 0;

  logic [63:0] exp_q[$];     // correct-path pcs expected at decode, in order
  logic [63:0] pend_addr[$]; // memory model: accepted, not yet answered
  int          pend_due[$];
  logic [63:0] exp_req;      // next address the fetcher must request

  int          lat      = 1;
  bit          rand_lat = 1'b0;

  logic        smp_out_valid;
  logic        smp_req_valid;
  logic        smp_req_fire;
  logic [31:0] smp_out_inst;
  logic [63:0] last_req_addr;
  logic [63:0] last_out_pc;

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hC3A5_0F0F;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic tick();
    bit resp_now;
    resp_now = 1'b0;
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_inst  = inst_of(pend_addr[0]);
      resp_now        = 1'b1;
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_inst  = $urandom;
    end
    #3;
    smp_out_valid = out_valid;
    smp_req_valid = imem_req_valid;
    smp_out_inst  = out_inst;
    smp_req_fire  = imem_req_valid && imem_req_ready;
    if (redirect_valid) begin
      check("redirect_out_valid", {63'd0, out_valid}, 64'd0);
      check("redirect_req_valid", {63'd0, imem_req_valid}, 64'd0);
    end
    if (imem_req_valid && imem_req_ready) begin
      check("req_addr", imem_req_addr, exp_req);
      exp_req = exp_req + 64'd4;
      last_req_addr = imem_req_addr;
      exp_q.push_back(imem_req_addr);
      pend_addr.push_back(imem_req_addr);
      pend_due.push_back(cyc + (rand_lat ? int'($urandom_range(1, 3)) : lat));
      n_req++;
    end
    if (resp_now) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    if (out_valid && out_ready) begin
      last_out_pc = out_pc;
      n_out++;
      if (exp_q.size() == 0) begin
        check("out_unexpected", out_pc, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("out_pc", out_pc, e);
        check("out_inst", {32'd0, out_inst}, {32'd0, inst_of(e)});
      end
    end
    if (redirect_valid) begin
      exp_req = {redirect_pc[63:2], 2'b00};
      exp_q.delete();
    end
    check("outstanding_bound", {63'd0, pend_addr.size() <= DEPTH}, 64'd1);
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst             = 1'b0;
    imem_resp_valid = 1'b0;
    redirect_valid  = 1'b0;
    @(posedge clk);
    cyc++;
    #1;
    pend_addr.delete();
    pend_due.delete();
    exp_q.delete();
    exp_req  = RST_PC;
    rand_lat = 1'b0;
    rst      = 1'b1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int base;
    int redir_left;
    rst             = 1'b0;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_inst  = '0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    out_ready       = 1'b1;
    exp_req         = RST_PC;
    last_req_addr   = '0;
    last_out_pc     = '0;

    // Reset values while rst is low.
    @(posedge clk); #3;
    check("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_pc", out_pc, 64'd0);
    check("rst_out_inst", {32'd0, out_inst}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Sequential stream, 1-cycle memory, decode always ready.
    lat = 1;
    tick();
    check("first_req_valid", {63'd0, smp_req_valid}, 64'd1);
    check("first_req_addr", last_req_addr, RST_PC);
    for (int i = 0; i < 3; i++) tick();
    for (int i = 0; i < 20; i++) begin
      tick();
      check("stream_no_gap", {63'd0, smp_out_valid}, 64'd1);
    end

    // Decode stalled: exactly DEPTH requests, then drain in order.
    do_reset();
    out_ready = 1'b0;
    base = n_req;
    for (int i = 0; i < 12; i++) tick();
    check("stall_req_count", 64'(n_req - base), 64'(DEPTH));
    check("stall_req_valid", {63'd0, smp_req_valid}, 64'd0);
    out_ready = 1'b1;
    base = n_out;
    for (int i = 0; i < 8; i++) tick();
    check("drain_count", {63'd0, (n_out - base) >= DEPTH}, 64'd1);
    check("requests_resume", {63'd0, (n_req - base) > 0}, 64'd1);

    // Redirect with two requests outstanding.
    do_reset();
    lat = 5;
    tick();
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0103;
    tick();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    lat = 1;
    tick();
    check("redir_req_fire", {63'd0, smp_req_fire}, 64'd1);
    check("redir_req_addr", last_req_addr, 64'h8000_0100);
    base = n_out;
    for (int i = 0; i < 30 && n_out == base; i++) tick();
    check("redir_out_seen", {63'd0, n_out > base}, 64'd1);
    check("redir_first_pc", last_out_pc, 64'h8000_0100);

    // Redirect in the same cycle as the only outstanding response.
    do_reset();
    lat = 2;
    tick();
    imem_req_ready = 1'b0;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_2002;
    tick();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    lat = 1;
    base = n_out;
    for (int i = 0; i < 30 && n_out == base; i++) tick();
    check("coincide_out_seen", {63'd0, n_out > base}, 64'd1);
    check("coincide_first_pc", last_out_pc, 64'h8000_2000);

    // Bypass vs queued latency with an empty queue.
    do_reset();
    lat = 1;
    out_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    tick();
    check("lat_resp_cycle_valid", {63'd0, smp_out_valid}, {63'd0, BYP});
    if (BYP) check("lat_bypass_inst", {32'd0, smp_out_inst}, {32'd0, inst_of(RST_PC)});
    tick();
    check("lat_next_cycle_valid", {63'd0, smp_out_valid}, {63'd0, !BYP});
    if (!BYP) check("lat_queued_inst", {32'd0, smp_out_inst}, {32'd0, inst_of(RST_PC)});

    // Random: toggling request ready, 1-3 cycle latency, random stalls and redirects.
    do_reset();
    rand_lat   = 1'b1;
    redir_left = 0;
    for (int i = 0; i < 500; i++) begin
      imem_req_ready = cyc[0];
      out_ready      = ($urandom_range(0, 3) != 0);
      if (redir_left == 0 && $urandom_range(0, 39) == 0) redir_left = $urandom_range(1, 2);
      if (redir_left > 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = {$urandom, $urandom};
        redir_left--;
      end else begin
        redirect_valid = 1'b0;
      end
      tick();
    end
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    imem_req_ready = 1'b1;
    base = n_out;
    for (int i = 0; i < 20; i++) tick();
    check("rand_resume", {63'd0, (n_out - base) >= 10}, 64'd1);

    // Final drain: every correct-path request must reach decode.
    imem_req_ready = 1'b0;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    check("final_drain", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
